// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and decode/control.
// align_fault exists only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
`ifdef FETCH_ALIGN_CHECK_EN
        output align_fault,
`endif
        input  imem_ready, imem_rdata, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
`ifdef FETCH_ALIGN_CHECK_EN
        input  align_fault,
`endif
        output imem_ready, imem_rdata, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ready handshake, registered instr to decode.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned redirects into a sticky FAULT state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [1:0] FAULT = 2'd2;
`endif

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        transfer;
    logic        misaligned;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    // A held instruction under stall blocks new requests; reset masks the request.
    always_comb begin
        bus.imem_req = !reset && (state == REQ) && (!instr_valid || !bus.stall);
    end

    assign transfer        = bus.imem_req && bus.imem_ready;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr;
    assign bus.instr_pc    = instr_pc;
    assign bus.instr_valid = instr_valid;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned      = bus.redirect_pc[1:0] != 2'b00;
    assign bus.align_fault = align_fault;
`else
    assign misaligned      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            align_fault <= 1'b0;
`endif
        end else begin
            if (state == IDLE) begin
                state <= REQ;
            end
            if (bus.redirect_valid) begin
                // Redirect flushes regardless of stall; any same-cycle transfer is dropped.
                instr       <= NOP_INSTR;
                instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                if (misaligned) begin
                    align_fault <= 1'b1;
                    state       <= FAULT;
                end else begin
                    pc <= bus.redirect_pc;
                end
`else
                pc <= bus.redirect_pc & ~32'h3 | {31'h0, misaligned};
`endif
            end else if (transfer) begin
                instr       <= bus.imem_rdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + 32'd4;
            end else if (instr_valid && !bus.stall) begin
                instr       <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory answers with address-tagged words.
// Covers FETCH_ALIGN_CHECK_EN both defined and undefined.
module tb_fetch_unit;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tagOf(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory model: returns the tagged word of whatever address is presented.
    always_comb bus.imem_rdata = tagOf(bus.imem_addr);

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic stl,
                                 input logic rv, input logic [31:0] rpc);
        bus.imem_ready     = ready;
        bus.stall          = stl;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkInstr(input string tag, input logic [31:0] pc);
        checkOutput({tag, ".valid"}, {31'h0, bus.instr_valid}, 32'd1);
        checkOutput({tag, ".pc"}, bus.instr_pc, pc);
        checkOutput({tag, ".instr"}, bus.instr, tagOf(pc));
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, ".valid"}, {31'h0, bus.instr_valid}, 32'd0);
        checkOutput({tag, ".nop"}, bus.instr, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("rst.req", {31'h0, bus.imem_req}, 32'd0);
        checkEmpty("rst");
        checkOutput("rst.ipc", bus.instr_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        checkOutput("rst.fault", {31'h0, bus.align_fault}, 32'd0);
`endif
        reset = 1'b0;
        #1;
        checkOutput("idle.req", {31'h0, bus.imem_req}, 32'd0);

        // Edge 1: IDLE -> REQ
        tick();
        checkOutput("e1.req", {31'h0, bus.imem_req}, 32'd1);
        checkOutput("e1.addr", bus.imem_addr, 32'h0040_0000);
        checkOutput("e1.valid", {31'h0, bus.instr_valid}, 32'd0);
        tick();
        checkInstr("e2", 32'h0040_0000);
        checkOutput("e2.addr", bus.imem_addr, 32'h0040_0004);
        tick();
        checkInstr("e3", 32'h0040_0004);

        // Stall three cycles with a live instruction
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall.req", {31'h0, bus.imem_req}, 32'd0);
            tick();
            checkInstr("stall", 32'h0040_0004);
            checkOutput("stall.addr", bus.imem_addr, 32'h0040_0008);
        end

        // Release stall with memory wait states on 0x00400008
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("wait.req", {31'h0, bus.imem_req}, 32'd1);
            checkOutput("wait.addr", bus.imem_addr, 32'h0040_0008);
            tick();
            checkEmpty("wait");
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkInstr("resume", 32'h0040_0008);
        checkOutput("resume.addr", bus.imem_addr, 32'h0040_000C);

        // Redirect in the same cycle as a transfer
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0040_0100);
        checkOutput("redir.req", {31'h0, bus.imem_req}, 32'd1);
        tick();
        checkEmpty("redir");
        checkOutput("redir.addr", bus.imem_addr, 32'h0040_0100);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkInstr("redir2", 32'h0040_0100);

        // Redirect under stall to the top of the address space, then wrap
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        checkEmpty("wrapredir");
        checkOutput("wrap.addr", bus.imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("stallidle.req", {31'h0, bus.imem_req}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkInstr("wrap1", 32'hFFFF_FFFC);
        checkOutput("wrap1.addr", bus.imem_addr, 32'h0000_0000);
        tick();
        checkInstr("wrap2", 32'h0000_0000);

        // Misaligned redirect
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0040_0102);
        tick();
        checkEmpty("mis");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            checkOutput("fault.flag", {31'h0, bus.align_fault}, 32'd1);
            checkOutput("fault.req", {31'h0, bus.imem_req}, 32'd0);
            tick();
            checkEmpty("fault");
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checkOutput("clear.fault", {31'h0, bus.align_fault}, 32'd0);
        checkOutput("clear.addr", bus.imem_addr, 32'h0040_0000);
`else
        checkOutput("mis.addr", bus.imem_addr, 32'h0040_0100);
        checkOutput("mis.req", {31'h0, bus.imem_req}, 32'd1);
        tick();
        checkInstr("mis2", 32'h0040_0100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
